// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types for the SPI master controller.
//   state_t      - controller FSM state encoding
//   ERR_*        - values reported on err_code_o
package spi_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_SHIFT_TX,
        ST_WAIT_ACK,
        ST_WAIT_READY,
        ST_SHIFT_RX,
        ST_FINISH,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_SEL     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// spi_sclk_gen: serial clock generator for the SPI master.
//   clk_i, rst_ni  - system clock, async active-low reset
//   en_i           - run the clock; when low sclk is parked low and the
//                    half-period counter is reloaded
//   sclk_o         - serial clock, CPOL=0
//   rise_en_o      - high in the clk cycle whose closing edge raises sclk
//   fall_en_o      - high in the clk cycle whose closing edge lowers sclk
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_en_o,
    output logic fall_en_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc        = (cnt_q == '0);
    assign rise_en_o = en_i & tc & ~sclk_q;
    assign fall_en_o = en_i & tc & sclk_q;
    assign sclk_o    = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = CNT_LOAD;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = CNT_LOAD;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= CNT_LOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: one register write or read per request over SPI.
//   clk_i, rst_ni         - system clock, async active-low reset
//   start_i, wr_i         - request strobe (taken in IDLE only), 1 = write
//   addr_i, data_in_i     - register address and write data
//   cs_sel_i              - peripheral select
//   ready_i, op_done_i    - peripheral handshakes (levels)
//   miso_i                - serial data in
//   sclk_o, cs_n_o, mosi_o- SPI bus (CPOL=0, LSB first)
//   data_out_o            - last successfully read data
//   busy_o, done_o        - transaction in flight / one-cycle completion
//   error_o, err_code_o   - sticky error flag and its cause
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_IDLE       | waiting for start
// ST_LOAD       | request captured
// ST_CHECK      | validate select/address, assert chip select
// ST_SHIFT_TX   | shift out {data, addr, wr} (write) or {addr, wr}
// ST_WAIT_ACK   | cs released, waiting for op_done
// ST_WAIT_READY | cs held, waiting for read data
// ST_SHIFT_RX   | shift in read data on sclk rises
// ST_FINISH     | done pulse
// ST_ERR        | done pulse with error set
module spi_master_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int MAX_ADDR = 31,
    parameter int NUM_CS   = 2,
    parameter int CLK_DIV  = 2,
    parameter int TIMEOUT  = 64,
    localparam int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [SEL_W-1:0]  cs_sel_i,
    input  logic              ready_i,
    input  logic              op_done_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic [NUM_CS-1:0] cs_n_o,
    output logic              mosi_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);

    import spi_master_pkg::*;

    localparam int FRAME_W = DATA_W + ADDR_W + 1;
    localparam int BIT_W   = $clog2(DATA_W + ADDR_W + 2);
    localparam int TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [TMO_W-1:0]  TMO_LOAD   = TMO_W'(TIMEOUT);
    // MAX_ADDR is expected to be representable in ADDR_W bits.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MAX_ADDR);
    localparam logic [NUM_CS-1:0] CS_ONE     = NUM_CS'(1);

    state_t              state_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SEL_W-1:0]    cs_sel_q;
    logic [FRAME_W-1:0]  tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [BIT_W-1:0]    bit_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic                mosi_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [1:0]          err_code_q;

    logic sclk_en, rise_en, fall_en, tmo_expired;

    assign sclk_en     = (state_q == ST_SHIFT_TX) || (state_q == ST_SHIFT_RX);
    // The count is loaded on entry to a wait state, so reaching 1 means
    // TIMEOUT cycles have been spent waiting. TIMEOUT=0 never expires.
    assign tmo_expired = (TIMEOUT != 0) && (tmo_q == TMO_W'(1));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (sclk_en),
        .sclk_o    (sclk_o),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            cs_sel_q   <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            tmo_q      <= '0;
            cs_n_q     <= '1;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        wr_q       <= wr_i;
                        addr_q     <= addr_i;
                        cs_sel_q   <= cs_sel_i;
                        tx_q       <= wr_i ? {data_in_i, addr_i, 1'b1}
                                           : {{DATA_W{1'b0}}, addr_i, 1'b0};
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (int'(cs_sel_q) >= NUM_CS) begin
                        err_code_q <= ERR_SEL;
                        state_q    <= ST_ERR;
                    end else if (addr_q > ADDR_LIMIT) begin
                        err_code_q <= ERR_ADDR;
                        state_q    <= ST_ERR;
                    end else begin
                        cs_n_q  <= ~(CS_ONE << cs_sel_q);
                        mosi_q  <= tx_q[0];
                        tx_q    <= tx_q >> 1;
                        bit_q   <= wr_q ? BIT_W'(FRAME_W - 1) : BIT_W'(ADDR_W);
                        state_q <= ST_SHIFT_TX;
                    end
                end
                ST_SHIFT_TX: begin
                    // Next bit goes out on the falling edge so mosi only moves while sclk is low.
                    if (fall_en) begin
                        if (bit_q == '0) begin
                            mosi_q <= 1'b0;
                            tmo_q  <= TMO_LOAD;
                            if (wr_q) begin
                                cs_n_q  <= '1;
                                state_q <= ST_WAIT_ACK;
                            end else begin
                                state_q <= ST_WAIT_READY;
                            end
                        end else begin
                            mosi_q <= tx_q[0];
                            tx_q   <= tx_q >> 1;
                            bit_q  <= bit_q - BIT_W'(1);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (op_done_i) begin
                        state_q <= ST_FINISH;
                    end else if (tmo_expired) begin
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_ERR;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                ST_WAIT_READY: begin
                    if (ready_i) begin
                        bit_q   <= BIT_W'(DATA_W - 1);
                        state_q <= ST_SHIFT_RX;
                    end else if (tmo_expired) begin
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_ERR;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                ST_SHIFT_RX: begin
                    if (rise_en) begin
                        rx_q <= (rx_q >> 1) | (DATA_W'(miso_i) << (DATA_W - 1));
                    end
                    if (fall_en) begin
                        if (bit_q == '0) begin
                            cs_n_q     <= '1;
                            data_out_q <= rx_q;
                            state_q    <= ST_FINISH;
                        end else begin
                            bit_q <= bit_q - BIT_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    cs_n_q  <= '1;
                    mosi_q  <= 1'b0;
                    error_q <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;
    assign data_out_o = data_out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, wr, ready, op_done, miso;
    logic [7:0] addr, data_in;
    logic [0:0] cs_sel;
    logic [1:0] cs_sel3;

    logic       sclk, mosi, busy, done, error;
    logic [1:0] cs_n, err_code;
    logic [7:0] data_out;

    logic       sclk3, mosi3, busy3, done3, error3;
    logic [2:0] cs_n3;
    logic [1:0] err_code3;
    logic [7:0] data_out3;

    always #5 clk = ~clk;

    spi_master_ctrl u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_i(wr),
        .addr_i(addr), .data_in_i(data_in), .cs_sel_i(cs_sel),
        .ready_i(ready), .op_done_i(op_done), .miso_i(miso),
        .sclk_o(sclk), .cs_n_o(cs_n), .mosi_o(mosi), .data_out_o(data_out),
        .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code)
    );

    spi_master_ctrl #(.NUM_CS(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_i(wr),
        .addr_i(addr), .data_in_i(data_in), .cs_sel_i(cs_sel3),
        .ready_i(ready), .op_done_i(op_done), .miso_i(miso),
        .sclk_o(sclk3), .cs_n_o(cs_n3), .mosi_o(mosi3), .data_out_o(data_out3),
        .busy_o(busy3), .done_o(done3), .error_o(error3), .err_code_o(err_code3)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        cs;
        logic        miso;
        int          lat;
        logic [1:0]  code;
        logic        err;
        int          rises;
        logic [16:0] frame;
        logic [1:0]  mask;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[7];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc, rises, done_cnt, cs_fall_cyc, cs_rise_cyc, rx_idx;
    logic        sclk_prev, rx_on;
    logic [31:0] frame;
    logic [1:0]  cs_mask;
    logic [7:0]  rx_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic clr_mon();
        cyc = -1; rises = 0; done_cnt = 0; frame = '0; cs_mask = '0;
        cs_fall_cyc = -1; cs_rise_cyc = -1; sclk_prev = sclk; rx_on = 1'b0; rx_idx = 0;
    endtask

    // One clock: advance to the falling edge and record bus activity.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sclk && !sclk_prev) begin
            if (rises < 32) frame[rises] = mosi;
            rises++;
            if (rx_on) begin
                rx_idx++;
                if (rx_idx < 8) miso = rx_val[rx_idx];
            end
        end
        sclk_prev = sclk;
        cs_mask   = cs_mask | ~cs_n;
        if (cs_n != 2'b11 && cs_fall_cyc < 0) cs_fall_cyc = cyc;
        if (cs_n == 2'b11 && cs_fall_cyc >= 0 && cs_rise_cyc < 0) cs_rise_cyc = cyc;
        if (done) done_cnt++;
    endtask

    task automatic begin_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input logic s);
        wr = w; addr = a; data_in = d; cs_sel = s; start = 1'b1;
        clr_mon();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (!done && cyc < limit) tick();
    endtask

    task automatic run_vec(input string pfx, input int i);
        vec_t v;
        v = vecs[i];
        miso = v.miso; ready = 1'b1; op_done = 1'b1;
        begin_txn(v.wr, v.addr, v.data, v.cs);
        check($sformatf("%s%0d_busy", pfx, i), busy, 1);
        wait_done(300);
        check($sformatf("%s%0d_lat", pfx, i), done ? cyc : -1, v.lat);
        check($sformatf("%s%0d_busy_end", pfx, i), busy, 0);
        check($sformatf("%s%0d_code", pfx, i), err_code, v.code);
        check($sformatf("%s%0d_err", pfx, i), error, v.err);
        check($sformatf("%s%0d_rises", pfx, i), rises, v.rises);
        check($sformatf("%s%0d_frame", pfx, i), frame, {15'd0, v.frame});
        check($sformatf("%s%0d_csmask", pfx, i), cs_mask, v.mask);
        check($sformatf("%s%0d_dout", pfx, i), data_out, v.dout);
    endtask

    initial begin
        int lat3;
        //              wr    addr   data   cs    miso  lat code  err rises frame      mask   dout
        vecs[0] = '{1'b1, 8'h05, 8'hA5, 1'b1, 1'b0, 72, 2'd0, 1'b0, 17, 17'h14A0B, 2'b10, 8'h00};
        vecs[1] = '{1'b0, 8'h03, 8'h00, 1'b0, 1'b1, 72, 2'd0, 1'b0, 17, 17'h00006, 2'b01, 8'hFF};
        vecs[2] = '{1'b1, 8'h20, 8'h55, 1'b0, 1'b0,  3, 2'd1, 1'b1,  0, 17'h00000, 2'b00, 8'hFF};
        vecs[3] = '{1'b1, 8'h1F, 8'hFF, 1'b0, 1'b0, 72, 2'd0, 1'b0, 17, 17'h1FE3F, 2'b01, 8'hFF};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b1,  3, 2'd1, 1'b1,  0, 17'h00000, 2'b00, 8'hFF};
        vecs[5] = '{1'b0, 8'h1F, 8'h00, 1'b1, 1'b0, 72, 2'd0, 1'b0, 17, 17'h0003E, 2'b10, 8'h00};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 72, 2'd0, 1'b0, 17, 17'h00001, 2'b10, 8'h00};

        rst_n = 1'b0; start = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        cs_sel = '0; cs_sel3 = '0; ready = 1'b0; op_done = 1'b0; miso = 1'b0;
        clr_mon();
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_code", err_code, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec("v", i);

        // Read with a late ready and a shifting miso pattern.
        ready = 1'b0; op_done = 1'b0; miso = 1'b0; rx_val = 8'h3C;
        begin_txn(1'b0, 8'h10, 8'h00, 1'b0);
        while (!(rises == 9 && !sclk) && cyc < 200) tick();
        check("rd_tx_end_cyc", cyc, 38);
        check("rd_first_bit", frame[0], 0);
        miso = rx_val[0]; rx_idx = 0; rx_on = 1'b1;
        repeat (5) tick();
        check("rd_wait_cs", cs_n, 2'b10);
        check("rd_wait_mosi", mosi, 0);
        ready = 1'b1;
        wait_done(300);
        ready = 1'b0; rx_on = 1'b0;
        check("rd_lat", done ? cyc : -1, 77);
        check("rd_dout", data_out, 8'h3C);
        check("rd_err", error, 0);
        check("rd_csmask", cs_mask, 2'b01);
        check("rd_rises", rises, 17);
        check("rd_frame", frame, 32'h0000_0020);

        // Asynchronous reset while the 6th bit is on the wire (sclk high).
        begin_txn(1'b1, 8'h10, 8'h00, 1'b1);
        while (rises < 6 && cyc < 200) tick();
        check("rs_pre_sclk", sclk, 1);
        check("rs_pre_mosi", mosi, 1);
        check("rs_pre_cs", cs_n, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("rs_cs_n", cs_n, 2'b11);
        check("rs_sclk", sclk, 0);
        check("rs_mosi", mosi, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);
        check("rs_dout", data_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec("post_rst_v", 0);

        // op_done never arrives: timeout after 64 cycles in WAIT_ACK.
        op_done = 1'b0; ready = 1'b0;
        begin_txn(1'b1, 8'h05, 8'hA5, 1'b1);
        wait_done(400);
        check("to_cs_fall", cs_fall_cyc, 2);
        check("to_cs_rise", cs_rise_cyc, 70);
        check("to_lat", done ? cyc : -1, 135);
        check("to_err", error, 1);
        check("to_code", err_code, 3);
        check("to_cs_n", cs_n, 2'b11);

        // op_done raised 3 cycles after cs release.
        begin_txn(1'b1, 8'h05, 8'hA5, 1'b1);
        while (cyc < 73) tick();
        op_done = 1'b1;
        wait_done(300);
        op_done = 1'b0;
        check("od_lat", done ? cyc : -1, 75);
        check("od_err", error, 0);
        check("od_code", err_code, 0);

        // A start pulsed mid-transfer must be ignored.
        op_done = 1'b1; ready = 1'b1;
        begin_txn(1'b1, 8'h05, 8'hA5, 1'b1);
        while (cyc < 10) tick();
        start = 1'b1; addr = 8'h20; cs_sel = 1'b0;
        tick();
        start = 1'b0;
        while (cyc < 150) tick();
        check("bz_done_cnt", done_cnt, 1);
        check("bz_err", error, 0);
        check("bz_frame", frame, 32'h0001_4A0B);

        // Invalid select on a 3-select instance outranks an invalid address.
        cs_sel3 = 2'd3;
        begin_txn(1'b1, 8'h28, 8'h00, 1'b0);
        lat3 = -1;
        for (int k = 0; k < 20; k++) begin
            if (done3 && lat3 < 0) begin
                lat3 = cyc;
                check("sel_code", err_code3, 2);
                check("sel_err", error3, 1);
                check("sel_cs_n", cs_n3, 3'b111);
                check("sel_busy", busy3, 0);
                check("sel_mosi", mosi3, 0);
                check("sel_sclk", sclk3, 0);
                check("sel_dout", data_out3, 0);
                check("addr_code_main", err_code, 1);
            end
            tick();
        end
        check("sel_lat", lat3, 3);
        check("sel_rises", rises, 0);
        cs_sel3 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
